fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage RV32I pipeline: PC register, PC+4 adder, branch/jump redirect and IF/ID pipeline register.
//   Drives the instruction memory address and presents INSTR_IF_ID_OUT, which feeds the HDU's INSTR_IF_ID_IN.
//   Consumes HDU stall controls (PC_EN, IF_ID_EN) and EX-stage redirect; flushes the wrong-path fetch on redirect.
// PARAMETERS
//   XLEN      32            datapath/address width
//   RESET_PC  32'h00400000  PC value loaded at reset (text segment base)
//   NOP_INSTR 32'h00000013  addi x0,x0,0 injected on reset/flush
// PORTS
//   CLK_IN            in   1     clock, rising edge
//   RSTN_IN           in   1     synchronous reset, active-low
//   PC_EN_IN          in   1     HDU: 1 = PC may advance, 0 = hold PC (load-use stall)
//   IF_ID_EN_IN       in   1     HDU: 1 = IF/ID captures, 0 = IF/ID holds
//   BRANCH_TAKEN_IN   in   1     EX: taken branch / jal / jalr this cycle
//   BRANCH_TARGET_IN  in   XLEN  EX: redirect target
//   IMEM_ADDR_OUT     out  XLEN  instruction memory address (= current PC)
//   IMEM_DATA_IN      in   32    instruction word at IMEM_ADDR_OUT, combinational read
//   PC_IF_ID_OUT      out  XLEN  PC of instruction held in IF/ID
//   PC4_IF_ID_OUT     out  XLEN  that PC + 4 (link value for jal/jalr)
//   INSTR_IF_ID_OUT   out  32    instruction held in IF/ID (to decoder and HDU)
//   VALID_IF_ID_OUT   out  1     1 = IF/ID holds a real fetched instruction
// BEHAVIOUR
//   Reset (RSTN_IN=0 at rising edge, overrides everything): PC<=RESET_PC; INSTR_IF_ID_OUT<=NOP_INSTR;
//     PC_IF_ID_OUT<=0; PC4_IF_ID_OUT<=0; VALID_IF_ID_OUT<=0. Reset mid-stall or mid-redirect discards both.
//   IMEM_ADDR_OUT is the PC register directly (no extra latency); fetched word reaches IF/ID one cycle later.
//   PC update priority per rising edge: reset > BRANCH_TAKEN_IN (PC<=target, ignores PC_EN_IN=0)
//     > PC_EN_IN (PC<=PC+4) > hold.
//   Target alignment: BRANCH_TARGET_IN[1:0] forced to 2'b00 before load (jalr LSB clear + word align).
//   PC+4 is modulo 2^XLEN: 32'hFFFFFFFC + 4 wraps to 32'h00000000, no flag.
//   IF/ID priority: reset > BRANCH_TAKEN_IN (flush: INSTR<=NOP_INSTR, VALID<=0, PC/PC4 fields <=0)
//     > IF_ID_EN_IN (capture IMEM_DATA_IN, PC, PC+4, VALID<=1) > hold all four fields unchanged.
//   Stall: PC_EN_IN=0 & IF_ID_EN_IN=0 for N cycles -> PC and IF/ID frozen N cycles, fetch resumes with same PC.
//   Simultaneous stall and redirect: redirect wins in both PC and IF/ID (stalled instr is wrong-path).
//   Mismatched enables (PC_EN_IN != IF_ID_EN_IN) are honoured independently; no internal consistency check.
//   Flush covers the IF/ID slot only; ID/EX flush on redirect belongs to the control path, not this block.
//   All outputs registered except IMEM_ADDR_OUT (= PC register, also registered). No combinational in->out path.
// STRUCTURE
//   Shared package rv_pkg: XLEN, RESET_PC, NOP_INSTR, INSTR_W=32 constants; if_id_t struct {pc,pc4,instr,valid}.
//   One sub-module: if_id_reg (enable + synchronous flush + reset register of if_id_t); PC logic stays top-level.
// TESTING
//   Reset: hold RSTN_IN=0 2 cycles -> IMEM_ADDR_OUT=32'h00400000, INSTR_IF_ID_OUT=32'h00000013, VALID=0.
//   Straight-line: enables=1, IMEM returns 32'h00A00293 @0x00400000 -> next cycle INSTR=32'h00A00293,
//     PC_IF_ID=32'h00400000, PC4_IF_ID=32'h00400004, IMEM_ADDR_OUT=32'h00400004.
//   Load-use stall: IF/ID holds 32'h00028333, drive PC_EN=0,IF_ID_EN=0 1 cycle -> PC and IF/ID unchanged,
//     then enables=1 -> fetch resumes at same PC, no instruction lost or duplicated.
//   Redirect during stall: PC_EN=0,IF_ID_EN=0,BRANCH_TAKEN=1,target=32'h00400023 -> PC=32'h00400020,
//     INSTR_IF_ID=32'h00000013, VALID=0.
//   Wrap: force PC=32'hFFFFFFFC via redirect, enables=1 -> next PC=32'h00000000, PC4_IF_ID=32'h00000000.
//   Reset mid-operation: RSTN_IN=0 while BRANCH_TAKEN=1 -> PC=RESET_PC, IF/ID=NOP/VALID=0, redirect ignored.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants, the IF/ID slot record and a PC alignment helper.
package rv_pkg;

  localparam int          XLEN      = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;  // text segment base
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Contents of the IF/ID pipeline slot
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  // Redirect targets are word aligned: clears the jalr LSB and bit 1 in one step
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
    return target & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous reset, synchronous flush, capture enable.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   en,
  input  if_id_t d,
  output if_id_t q
);

  // Reset and flush both leave an invalid bubble carrying a NOP
  localparam if_id_t BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

  // Slot update: reset > flush > capture > hold
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch of the
    // clocked block; non-blocking assignments keep every flop reading pre-edge values.
    if (!rst_n) begin
      q <= BUBBLE;
    end else if (flush) begin
      q <= BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, PC+4 adder, EX redirect and IF/ID slot.
// The if_id_t record is sized by rv_pkg::XLEN, so XLEN must stay equal to it.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int                 XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC  = rv_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic               CLK_IN,
  input  logic               RSTN_IN,
  input  logic               PC_EN_IN,
  input  logic               IF_ID_EN_IN,
  input  logic               BRANCH_TAKEN_IN,
  input  logic [XLEN-1:0]    BRANCH_TARGET_IN,
  output logic [XLEN-1:0]    IMEM_ADDR_OUT,
  input  logic [INSTR_W-1:0] IMEM_DATA_IN,
  output logic [XLEN-1:0]    PC_IF_ID_OUT,
  output logic [XLEN-1:0]    PC4_IF_ID_OUT,
  output logic [INSTR_W-1:0] INSTR_IF_ID_OUT,
  output logic               VALID_IF_ID_OUT
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  // Sequential successor; wraps modulo 2^XLEN with no carry out
  assign pc_plus4 = pc_q + XLEN'(4);

  // PC register: reset > redirect (overrides a stall) > advance > hold
  always_ff @(posedge CLK_IN) begin
    if (!RSTN_IN) begin
      pc_q <= RESET_PC;
    end else if (BRANCH_TAKEN_IN) begin
      pc_q <= align_pc(BRANCH_TARGET_IN);
    end else if (PC_EN_IN) begin
      pc_q <= pc_plus4;
    end
  end

  // Record offered to IF/ID: the word fetched from the current PC
  always_comb begin
    if_id_d = '{pc: pc_q, pc4: pc_plus4, instr: IMEM_DATA_IN, valid: 1'b1};
  end

  // A redirect squashes the wrong-path fetch sitting in IF
  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (CLK_IN),
    .rst_n (RSTN_IN),
    .flush (BRANCH_TAKEN_IN),
    .en    (IF_ID_EN_IN),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign IMEM_ADDR_OUT   = pc_q;
  assign PC_IF_ID_OUT    = if_id_q.pc;
  assign PC4_IF_ID_OUT   = if_id_q.pc4;
  assign INSTR_IF_ID_OUT = if_id_q.instr;
  assign VALID_IF_ID_OUT = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a multi-cycle stall
// sequence, then randomized traffic against a behavioural model of the IF stage.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pc_en;
  logic        if_id_en;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc_if_id;
  logic [31:0] pc4_if_id;
  logic [31:0] instr_if_id;
  logic        valid_if_id;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_slot_pc;
  logic [31:0] m_slot_pc4;
  logic [31:0] m_slot_instr;
  logic        m_slot_valid;

  fetch_stage dut (
    .CLK_IN           (clk),
    .RSTN_IN          (rstn),
    .PC_EN_IN         (pc_en),
    .IF_ID_EN_IN      (if_id_en),
    .BRANCH_TAKEN_IN  (br),
    .BRANCH_TARGET_IN (tgt),
    .IMEM_ADDR_OUT    (imem_addr),
    .IMEM_DATA_IN     (imem_data),
    .PC_IF_ID_OUT     (pc_if_id),
    .PC4_IF_ID_OUT    (pc4_if_id),
    .INSTR_IF_ID_OUT  (instr_if_id),
    .VALID_IF_ID_OUT  (valid_if_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        pc_en;
    logic        if_id_en;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                           input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_valid);
    check({tag, ".addr"},  imem_addr,          e_addr);
    check({tag, ".pc"},    pc_if_id,           e_pc);
    check({tag, ".pc4"},   pc4_if_id,          e_pc4);
    check({tag, ".instr"}, instr_if_id,        e_instr);
    check({tag, ".valid"}, {31'b0, valid_if_id}, {31'b0, e_valid});
  endtask

  // Model of one clock edge, written from the stage's rules: reset wins, a redirect
  // jumps to the word-aligned target and squashes IF/ID, otherwise each enable acts
  // on its own register using the PC that was current before the edge.
  task automatic model_edge(input logic r, input logic pe, input logic ie, input logic b,
                            input logic [31:0] t, input logic [31:0] d);
    if (!r) begin
      m_pc = RST_PC;
      m_slot_pc = 0; m_slot_pc4 = 0; m_slot_instr = NOP; m_slot_valid = 1'b0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00};
      m_slot_pc = 0; m_slot_pc4 = 0; m_slot_instr = NOP; m_slot_valid = 1'b0;
    end else begin
      if (ie) begin
        m_slot_pc = m_pc; m_slot_pc4 = m_pc + 32'd4; m_slot_instr = d; m_slot_valid = 1'b1;
      end
      if (pe) m_pc = m_pc + 32'd4;
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle past the edge
  task automatic step(input logic r, input logic pe, input logic ie, input logic b,
                      input logic [31:0] t, input logic [31:0] d);
    rstn = r; pc_en = pe; if_id_en = ie; br = b; tgt = t; imem_data = d;
    @(posedge clk);
    model_edge(r, pe, ie, b, t, d);
    #1;
  endtask

  initial begin
    rstn = 1'b0; pc_en = 1'b0; if_id_en = 1'b0; br = 1'b0; tgt = '0; imem_data = '0;
    m_pc = '0; m_slot_pc = '0; m_slot_pc4 = '0; m_slot_instr = '0; m_slot_valid = 1'b0;

    //            rstn pe   ie   br   target         imem data      addr           pc             pc4            instr          v
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0000_0000,32'h0000_0000,32'h0040_0000,32'h0000_0000,32'h0000_0000,NOP,          1'b0});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0000_0000,32'h0000_0000,32'h0040_0000,32'h0000_0000,32'h0000_0000,NOP,          1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b0,32'h0000_0000,32'h00A0_0293,32'h0040_0004,32'h0040_0000,32'h0040_0004,32'h00A0_0293,1'b1});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b0,32'h0000_0000,32'h0002_8333,32'h0040_0008,32'h0040_0004,32'h0040_0008,32'h0002_8333,1'b1});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h1234_5678,32'h0040_0008,32'h0040_0004,32'h0040_0008,32'h0002_8333,1'b1});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b0,32'h0000_0000,32'h0053_0333,32'h0040_000C,32'h0040_0008,32'h0040_000C,32'h0053_0333,1'b1});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b1,32'h0040_0023,32'hDEAD_BEEF,32'h0040_0020,32'h0000_0000,32'h0000_0000,NOP,          1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b0,32'h0000_0000,32'h0010_0093,32'h0040_0024,32'h0040_0020,32'h0040_0024,32'h0010_0093,1'b1});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b1,32'hFFFF_FFFE,32'hCAFE_F00D,32'hFFFF_FFFC,32'h0000_0000,32'h0000_0000,NOP,          1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b0,32'h0000_0000,32'h0020_0113,32'h0000_0000,32'hFFFF_FFFC,32'h0000_0000,32'h0020_0113,1'b1});
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,32'h0000_0000,32'h1111_1111,32'h0000_0004,32'hFFFF_FFFC,32'h0000_0000,32'h0020_0113,1'b1});
    tbl.push_back('{1'b1,1'b0,1'b1,1'b0,32'h0000_0000,32'h2222_2222,32'h0000_0004,32'h0000_0004,32'h0000_0008,32'h2222_2222,1'b1});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,32'h8000_0000,32'h3333_3333,32'h0040_0000,32'h0000_0000,32'h0000_0000,NOP,          1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b0,32'h0000_0000,32'h0000_0297,32'h0040_0004,32'h0040_0000,32'h0040_0004,32'h0000_0297,1'b1});

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rstn, tbl[i].pc_en, tbl[i].if_id_en, tbl[i].br, tbl[i].tgt, tbl[i].data);
      check_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_pc4,
                tbl[i].e_instr, tbl[i].e_valid);
    end

    // Three-cycle load-use stall: everything frozen, then fetch resumes at the same PC
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hBAD0_0000 | 32'(k));
      check_all($sformatf("stall%0d", k), 32'h0040_0004, 32'h0040_0000, 32'h0040_0004,
                32'h0000_0297, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0313);
    check_all("resume", 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 32'h0000_0313, 1'b1);

    // Randomized traffic against the model
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_all("rnd_reset", m_pc, m_slot_pc, m_slot_pc4, m_slot_instr, m_slot_valid);
    for (int n = 0; n < 400; n++) begin
      logic        r, pe, ie, b;
      logic [31:0] t, d;
      r  = ($urandom_range(0, 39) != 0);
      pe = ($urandom_range(0, 3) != 0);
      ie = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 5) == 0);
      t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      d  = $urandom;
      step(r, pe, ie, b, t, d);
      check_all($sformatf("rnd%0d", n), m_pc, m_slot_pc, m_slot_pc4, m_slot_instr, m_slot_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
